// File: rtl/sd_emmc_ddr_rx.sv
// SD/eMMC DDR block receiver: waits for the start bit, captures one data block,
// checks the per-line, per-edge CRC16 values and the end bit, then reports status.
module sd_emmc_ddr_rx #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*DATA_WIDTH-1:0] din,
    input  logic                    start,
    input  logic                    abort,
    output logic [2*DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    crc_err,
    output logic                    end_err,
    output logic                    timeout
);

    localparam int unsigned Lanes  = 2 * DATA_WIDTH;
    localparam int unsigned Beats  = BLOCK_BYTES * 8 / Lanes;
    localparam int unsigned MaxA   = (Beats > TIMEOUT_CYCLES) ? Beats : TIMEOUT_CYCLES;
    localparam int unsigned CntMax = (MaxA > 16) ? MaxA : 16;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StWaitStart, StData, StCrc, StEnd} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_inc;
    logic [15:0]      crc_q    [Lanes];
    logic [15:0]      crc_next [Lanes];
    logic [3:0]       crc_idx;
    logic [Lanes-1:0] crc_mismatch;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign cnt_inc = cnt_q + 1'b1;
    assign busy    = (state_q != StIdle);
    // During CRC, cycle k carries bit 15-k of each lane's register.
    assign crc_idx = 4'd15 - cnt_q[3:0];

    always_comb begin
        for (int i = 0; i < Lanes; i++) begin
            crc_next[i]     = crc16_step(crc_q[i], din[i]);
            crc_mismatch[i] = din[i] ^ crc_q[i][crc_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            crc_err    <= 1'b0;
            end_err    <= 1'b0;
            timeout    <= 1'b0;
            for (int i = 0; i < Lanes; i++) crc_q[i] <= '0;
        end else begin
            done       <= 1'b0;
            dout_valid <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StWaitStart;
                            cnt_q   <= '0;
                            crc_err <= 1'b0;
                            end_err <= 1'b0;
                            timeout <= 1'b0;
                            for (int i = 0; i < Lanes; i++) crc_q[i] <= '0;
                        end
                    end
                    StWaitStart: begin
                        if (din == '0) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                        end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                            cnt_q   <= cnt_inc;
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StData: begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                        for (int i = 0; i < Lanes; i++) crc_q[i] <= crc_next[i];
                        if (cnt_q == CntW'(Beats - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StCrc;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StCrc: begin
                        if (|crc_mismatch) crc_err <= 1'b1;
                        if (cnt_q == CntW'(15)) begin
                            cnt_q   <= '0;
                            state_q <= StEnd;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StEnd: begin
                        if (din != '1) end_err <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/sd_emmc_ddr_rx.md
SD_EMMC_DDR_RX -- requirements
Module: sd_emmc_ddr_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, DAT line count (legal 1, 4, 8).
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, data bytes per block; BLOCK_BYTES*8 SHALL be divisible by 2*DATA_WIDTH.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, start-bit wait limit in clk cycles.
REQ-004 clk  input  1  sole clock; every register SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  2*DATA_WIDTH  pre-captured DDR sample pair per cycle: [DATA_WIDTH-1:0] rising-edge bits, [2*DATA_WIDTH-1:DATA_WIDTH] falling-edge bits.
REQ-007 start  input  1  single-cycle pulse that arms reception of one block.
REQ-008 abort  input  1  level; forces return to IDLE.
REQ-009 dout  output  2*DATA_WIDTH  received data pair, same bit layout as din.
REQ-010 dout_valid  output  1  dout qualifier; no backpressure.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  single-cycle pulse at end of block.
REQ-013 crc_err, end_err, timeout  output  1 each  sticky status flags.

Function
REQ-014 SHALL implement states IDLE, WAIT_START, DATA, CRC, END.
REQ-015 IDLE: start=1 -> WAIT_START and clear crc_err, end_err, timeout, the timeout counter, and all CRC registers; start in any other state SHALL be ignored.
REQ-016 WAIT_START: start bit = all 2*DATA_WIDTH din bits 0 in one cycle -> DATA from the next cycle; a partial-zero pattern SHALL NOT be a start bit.
REQ-017 WAIT_START: counter increments each cycle without a start bit; reaching TIMEOUT_CYCLES -> timeout=1, done pulse, IDLE.
REQ-018 DATA: SHALL last exactly BLOCK_BYTES*8/(2*DATA_WIDTH) cycles; each cycle dout<=din and dout_valid=1, registered, i.e. one cycle after the sample.
REQ-019 DATA: SHALL update 2*DATA_WIDTH independent CRC16 registers (x^16+x^12+x^5+1, init 0x0000, MSB first): one per line per edge.
REQ-020 CRC: 16 cycles; cycle k SHALL compare din bit of each line/edge with bit 15-k of its register; any mismatch sets crc_err.
REQ-021 END: one cycle; any din bit 0 sets end_err; then done pulse and IDLE in the following cycle.
REQ-022 dout_valid SHALL be 0 outside DATA sample cycles; dout holds its last value.
REQ-023 done SHALL assert in the same cycle busy deasserts; crc_err/end_err/timeout SHALL be valid when done=1 and held until next accepted start.
REQ-024 abort=1 in any state -> IDLE next cycle, no done pulse, dout_valid=0, flags unchanged; abort wins over simultaneous start.
REQ-025 Cycle counter SHALL be sized for max(BLOCK_BYTES*8/(2*DATA_WIDTH), TIMEOUT_CYCLES) without wrap.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE; dout=0, dout_valid=0, busy=0, done=0, crc_err=0, end_err=0, timeout=0, counters and CRC registers 0.
REQ-027 Reset mid-block SHALL discard the block with no done pulse after release; first cycle after release SHALL accept start.

Verification
REQ-028 DATA_WIDTH=4, BLOCK_BYTES=4: start, din=0x00, then 0x12,0x34,0x56,0x78, correct CRCs, din=0xFF -> dout_valid for 4 cycles with dout 0x12..0x78 each one cycle late, done=1, all flags 0.
REQ-029 Same block with one CRC bit of line 2 falling edge flipped -> done=1, crc_err=1, end_err=0.
REQ-030 Same block with end cycle din=0xFE -> done=1, end_err=1, crc_err=0.
REQ-031 TIMEOUT_CYCLES=10, start with din held 0xFF -> done=1 and timeout=1 exactly 10 cycles after entering WAIT_START, no dout_valid.
REQ-032 abort in 2nd DATA cycle, then rst_n pulse during next block's DATA -> both return to IDLE, no done, dout_valid=0; following start completes a clean block.
REQ-033 start while busy, and din=0x0F (partial zero) in WAIT_START -> both ignored, reception unchanged.
